// File: rtl/dir_input_encoder_if.sv
// ---------------------------------------------------------------------------
// dir_input_encoder_if
//
// Purpose:
//   Groups the keyboard-side inputs and the motion-side outputs of
//   dir_input_encoder into one bundle. The clock and reset stay as plain
//   ports on the encoder itself.
//
// Signals:
//   keycode     8  raw USB HID keycode, 0x00 when no key is pressed
//   frame_tick  1  one-cycle pulse per video frame
//   USER_INPUT  3  movement code (001 up, 010 left, 100 down, 101 right)
//   move_valid  1  one-cycle step strobe, coincident with USER_INPUT
//   held_dir    3  direction currently accepted as held (000 when none)
//
// Modports:
//   master  drives keycode/frame_tick, observes the encoder outputs
//   slave   the encoder side
// ---------------------------------------------------------------------------
interface dir_input_encoder_if;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [2:0] USER_INPUT;
  logic       move_valid;
  logic [2:0] held_dir;

  modport master (
    output keycode,
    output frame_tick,
    input  USER_INPUT,
    input  move_valid,
    input  held_dir
  );

  modport slave (
    input  keycode,
    input  frame_tick,
    output USER_INPUT,
    output move_valid,
    output held_dir
  );
endinterface

// File: rtl/dir_input_encoder.sv
// ---------------------------------------------------------------------------
// dir_input_encoder
//
// Purpose:
//   Turns the raw keyboard keycode into single-cycle movement steps for the
//   sprite motion logic. The keycode is looked at only on frame ticks, is
//   debounced over whole frames, and a held key produces a first step,
//   then (after a hold delay) a steady stream of auto-repeat steps.
//
// Ports:
//   Clk    in   system clock
//   Reset  in   synchronous reset, active-high, highest priority
//   bus    slave side of dir_input_encoder_if:
//            keycode, frame_tick in; USER_INPUT, move_valid, held_dir out
//
// Parameters:
//   STABLE_FRAMES  ticks a direction must be seen before the first step
//   REPEAT_DELAY   ticks after the first step before auto-repeat starts
//   REPEAT_PERIOD  ticks between auto-repeat steps
//   All three are legal in 1..255.
// ---------------------------------------------------------------------------
module dir_input_encoder #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  dir_input_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    REPEAT   = 2'd3
  } state_t;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;

  localparam logic [7:0] STABLE_TARGET = 8'(STABLE_FRAMES);
  localparam logic [7:0] DELAY_TARGET  = 8'(REPEAT_DELAY);
  localparam logic [7:0] PERIOD_TARGET = 8'(REPEAT_PERIOD);

  // A one-frame debounce accepts a new direction on the very tick it appears.
  localparam logic SINGLE_FRAME = (STABLE_FRAMES == 1) ? 1'b1 : 1'b0;

  // Map the HID keycode onto a movement code: WASD and the arrow keys.
  function automatic logic [2:0] decode_key(input logic [7:0] key);
    logic [2:0] dir;
    dir = DIR_NONE;
    case (key)
      8'h1A, 8'h52: dir = DIR_UP;
      8'h04, 8'h50: dir = DIR_LEFT;
      8'h16, 8'h51: dir = DIR_DOWN;
      8'h07, 8'h4F: dir = DIR_RIGHT;
      default:      dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // Frame counters stick at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  state_t     state;
  logic [2:0] cand;
  logic [7:0] cnt;
  logic [2:0] step_code;
  logic       step_valid;
  logic [2:0] held;

  logic [2:0] d;
  logic [7:0] cnt_inc;
  logic [7:0] repeat_target;
  state_t     start_state;
  logic [7:0] start_cnt;
  logic       start_emit;
  logic [2:0] start_held;

  // Decode, counter increment, and the "new direction seen" landing point
  // shared by IDLE and by a direction change in any other state.
  always_comb begin
    d             = decode_key(bus.keycode);
    cnt_inc       = sat_inc(cnt);
    repeat_target = (state == HOLD) ? DELAY_TARGET : PERIOD_TARGET;
    if (SINGLE_FRAME) begin
      start_state = HOLD;
      start_cnt   = 8'd0;
      start_emit  = 1'b1;
      start_held  = d;
    end else begin
      start_state = DEBOUNCE;
      start_cnt   = 8'd1;
      start_emit  = 1'b0;
      start_held  = DIR_NONE;
    end
  end

  // Debounce / hold / auto-repeat state machine with registered outputs.
  // State only advances on frame ticks; step outputs are pulsed for one
  // cycle and cleared by default every other cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cand       <= DIR_NONE;
      cnt        <= 8'd0;
      step_code  <= DIR_NONE;
      step_valid <= 1'b0;
      held       <= DIR_NONE;
    end else begin
      step_code  <= DIR_NONE;
      step_valid <= 1'b0;
      if (bus.frame_tick) begin
        case (state)
          IDLE: begin
            if (d != DIR_NONE) begin
              state      <= start_state;
              cand       <= d;
              cnt        <= start_cnt;
              held       <= start_held;
              step_code  <= start_emit ? d : DIR_NONE;
              step_valid <= start_emit;
            end
          end

          DEBOUNCE: begin
            if (d == DIR_NONE) begin
              state <= IDLE;
              cand  <= DIR_NONE;
              cnt   <= 8'd0;
              held  <= DIR_NONE;
            end else if (d == cand) begin
              if (cnt_inc == STABLE_TARGET) begin
                state      <= HOLD;
                cnt        <= 8'd0;
                held       <= cand;
                step_code  <= cand;
                step_valid <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // A different direction restarts the debounce from scratch.
              state      <= start_state;
              cand       <= d;
              cnt        <= start_cnt;
              held       <= start_held;
              step_code  <= start_emit ? d : DIR_NONE;
              step_valid <= start_emit;
            end
          end

          // HOLD waits out the repeat delay; REPEAT then steps every period.
          // Both land in REPEAT on reaching their target.
          HOLD, REPEAT: begin
            if (d == DIR_NONE) begin
              state <= IDLE;
              cand  <= DIR_NONE;
              cnt   <= 8'd0;
              held  <= DIR_NONE;
            end else if (d == cand) begin
              if (cnt_inc == repeat_target) begin
                state      <= REPEAT;
                cnt        <= 8'd0;
                step_code  <= cand;
                step_valid <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Switching keys while held re-debounces the new direction.
              state      <= start_state;
              cand       <= d;
              cnt        <= start_cnt;
              held       <= start_held;
              step_code  <= start_emit ? d : DIR_NONE;
              step_valid <= start_emit;
            end
          end

          default: begin
            state <= IDLE;
            cand  <= DIR_NONE;
            cnt   <= 8'd0;
            held  <= DIR_NONE;
          end
        endcase
      end
    end
  end

  assign bus.USER_INPUT = step_code;
  assign bus.move_valid = step_valid;
  assign bus.held_dir   = held;

endmodule

// File: tb/tb_dir_input_encoder.sv
// ---------------------------------------------------------------------------
// tb_dir_input_encoder
//
// Two encoder instances: dut_a with the default timing (2/8/2) and dut_b
// with a one-frame debounce (1/3/1). A table of per-cycle records holds the
// drive values and the hand-derived outputs expected after that clock edge.
// Expected outputs are queued when a record is driven and popped/compared
// once the edge has produced the DUT response.
// ---------------------------------------------------------------------------
module tb_dir_input_encoder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_a;
  logic rst_b;

  dir_input_encoder_if if_a ();
  dir_input_encoder_if if_b ();

  dir_input_encoder #(
    .STABLE_FRAMES (2),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (2)
  ) dut_a (
    .Clk   (Clk),
    .Reset (rst_a),
    .bus   (if_a.slave)
  );

  dir_input_encoder #(
    .STABLE_FRAMES (1),
    .REPEAT_DELAY  (3),
    .REPEAT_PERIOD (1)
  ) dut_b (
    .Clk   (Clk),
    .Reset (rst_b),
    .bus   (if_b.slave)
  );

  typedef struct {
    logic       sel;   // 0 = dut_a, 1 = dut_b
    logic       rst;
    logic [7:0] key;
    logic       tick;
    logic [2:0] ui;
    logic       mv;
    logic [2:0] held;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [2:0] ui;
    logic       mv;
    logic [2:0] held;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic void add(input logic sel, input logic rst, input logic [7:0] key,
                              input logic tick, input logic [2:0] ui, input logic mv,
                              input logic [2:0] held);
    vec_t v;
    v.sel  = sel;
    v.rst  = rst;
    v.key  = key;
    v.tick = tick;
    v.ui   = ui;
    v.mv   = mv;
    v.held = held;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp_v);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t       e;
    exp_t       got;
    logic [2:0] ui;
    logic       mv;
    logic [2:0] held;
    @(negedge Clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.keycode = 8'h00;
    if_a.frame_tick = 1'b0;
    if_b.keycode = 8'h00;
    if_b.frame_tick = 1'b0;
    if (v.sel == 1'b0) begin
      rst_a = v.rst;
      if_a.keycode = v.key;
      if_a.frame_tick = v.tick;
    end else begin
      rst_b = v.rst;
      if_b.keycode = v.key;
      if_b.frame_tick = v.tick;
    end
    e.sel  = v.sel;
    e.ui   = v.ui;
    e.mv   = v.mv;
    e.held = v.held;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
    end else begin
      got = sb.pop_front();
      if (got.sel == 1'b0) begin
        ui = if_a.USER_INPUT; mv = if_a.move_valid; held = if_a.held_dir;
      end else begin
        ui = if_b.USER_INPUT; mv = if_b.move_valid; held = if_b.held_dir;
      end
      check("USER_INPUT", idx, {5'd0, ui},   {5'd0, got.ui});
      check("move_valid", idx, {7'd0, mv},   {7'd0, got.mv});
      check("held_dir",   idx, {5'd0, held}, {5'd0, got.held});
    end
  endtask

  initial begin
    logic em;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.keycode = 8'h00;
    if_a.frame_tick = 1'b0;
    if_b.keycode = 8'h00;
    if_b.frame_tick = 1'b0;

    // ---- dut_b: one-frame debounce, back-to-back ticks ----
    add(1, 1, 8'h16, 1, 3'b000, 0, 3'b000);
    add(1, 1, 8'h16, 1, 3'b000, 0, 3'b000);
    add(1, 0, 8'h16, 1, 3'b100, 1, 3'b100);   // immediate accept
    add(1, 0, 8'h16, 1, 3'b000, 0, 3'b100);   // hold cnt 1
    add(1, 0, 8'h16, 1, 3'b000, 0, 3'b100);   // hold cnt 2
    add(1, 0, 8'h16, 1, 3'b100, 1, 3'b100);   // delay 3 reached
    add(1, 0, 8'h16, 1, 3'b100, 1, 3'b100);   // repeat every tick
    add(1, 0, 8'h16, 1, 3'b100, 1, 3'b100);
    add(1, 0, 8'h16, 0, 3'b000, 0, 3'b100);   // no tick: no step
    add(1, 0, 8'h4F, 1, 3'b101, 1, 3'b101);   // change with 1-frame debounce
    add(1, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    // ---- dut_a: reset with key held and ticks running ----
    add(0, 1, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 1, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 1, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h1A, 1, 3'b001, 1, 3'b001);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);   // release from HOLD: no emit

    // ---- 0x07 held over 20 ticks; idle cycles carry 0x00 which must be ignored ----
    for (int k = 1; k <= 20; k++) begin
      em = (k == 2) || (k >= 10 && (k % 2) == 0);
      add(0, 0, 8'h07, 1, em ? 3'b101 : 3'b000, em, (k >= 2) ? 3'b101 : 3'b000);
      add(0, 0, 8'h00, 0, 3'b000, 0, (k >= 2) ? 3'b101 : 3'b000);
    end
    add(0, 0, 8'h16, 1, 3'b000, 0, 3'b000);   // change during REPEAT
    add(0, 0, 8'h16, 1, 3'b100, 1, 3'b100);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    // ---- single tick then release; debounce must restart ----
    add(0, 0, 8'h04, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h04, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h04, 1, 3'b010, 1, 3'b010);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    // ---- change during DEBOUNCE ----
    add(0, 0, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h50, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h50, 1, 3'b010, 1, 3'b010);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    // ---- direction switch while held ----
    add(0, 0, 8'h52, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h52, 1, 3'b001, 1, 3'b001);
    add(0, 0, 8'h52, 1, 3'b000, 0, 3'b001);
    add(0, 0, 8'h52, 1, 3'b000, 0, 3'b001);
    add(0, 0, 8'h51, 1, 3'b000, 0, 3'b000);   // tick 5: re-debounce
    add(0, 0, 8'h51, 1, 3'b100, 1, 3'b100);   // tick 6: emit down
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    // ---- unmapped keycode ----
    for (int k = 0; k < 10; k++) add(0, 0, 8'h2C, 1, 3'b000, 0, 3'b000);

    // ---- reset while in REPEAT ----
    for (int k = 1; k <= 13; k++) begin
      em = (k == 2) || (k == 10) || (k == 12);
      add(0, 0, 8'h1A, 1, em ? 3'b001 : 3'b000, em, (k >= 2) ? 3'b001 : 3'b000);
    end
    add(0, 1, 8'h1A, 1, 3'b000, 0, 3'b000);   // tick 14 would emit; reset wins
    add(0, 1, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h1A, 1, 3'b000, 0, 3'b000);
    add(0, 0, 8'h1A, 1, 3'b001, 1, 3'b001);
    add(0, 0, 8'h00, 1, 3'b000, 0, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dir_input_encoder.md
Name: dir_input_encoder

Overview:
- Converts the raw 8-bit USB HID keycode from the keyboard path into the 3-bit movement code consumed by the sprite motion logic: 001 up, 010 left, 100 down, 101 right, 000 none.
- Samples the keycode once per frame tick and debounces it over whole frames.
- Applies a hold-delay / auto-repeat policy and issues single-cycle step codes.
- The position register downstream updates only when move_valid is high.

Parameters:
- STABLE_FRAMES, 2, consecutive frame ticks a direction must be seen before the first step; legal 1..255.
- REPEAT_DELAY, 8, frame ticks after the first step before auto-repeat begins; legal 1..255.
- REPEAT_PERIOD, 2, frame ticks between auto-repeat steps; legal 1..255.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous reset, active-high.
- keycode  input  8  current USB HID keycode; 0x00 when no key is pressed.
- frame_tick  input  1  one-cycle pulse per video frame (vsync edge).
- USER_INPUT  output  3  movement code; non-zero only in a step cycle.
- move_valid  output  1  one-cycle step strobe, coincident with USER_INPUT.
- held_dir  output  3  currently accepted direction; 000 in IDLE/DEBOUNCE.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset state: state=IDLE, cand=000, cnt=0, USER_INPUT=000, move_valid=0, held_dir=000.
- Decode (combinational, d):
  - 0x1A or 0x52 -> 001
  - 0x04 or 0x50 -> 010
  - 0x16 or 0x51 -> 100
  - 0x07 or 0x4F -> 101
  - any other value -> 000
- Keycode is examined only in cycles where frame_tick=1. In all other cycles state, cand and cnt hold.
- "Emit" means: in the cycle after the tick, USER_INPUT=cand and move_valid=1. Both return to 000/0 the following cycle. Latency is exactly 1 clock from the tick. Both outputs are registered.
- States (all transitions occur on tick cycles):
  - IDLE:
    - d=000 -> stay.
    - d!=000 -> cand=d.
      - If STABLE_FRAMES=1: emit, go HOLD, cnt=0.
      - Else: go DEBOUNCE, cnt=1.
  - DEBOUNCE:
    - d=cand -> cnt+1. When it reaches STABLE_FRAMES: emit, go HOLD, cnt=0.
    - d=000 -> IDLE.
    - d is another direction -> cand=d, cnt=1 (restart; STABLE_FRAMES=1 emits immediately).
  - HOLD:
    - d=cand -> cnt+1. When it reaches REPEAT_DELAY: emit, go REPEAT, cnt=0.
    - d=000 -> IDLE, no emit.
    - d is another direction -> handled exactly as IDLE with the new d (re-debounce).
  - REPEAT:
    - d=cand -> cnt+1. When it reaches REPEAT_PERIOD: emit, cnt=0.
    - d=000 or a change -> same as HOLD.
- held_dir = cand while in HOLD or REPEAT, else 000. It is registered and updates with the state.
- Back-to-back ticks on consecutive cycles are each counted. An emit can therefore follow the previous one by a single cycle.
- Counters are 8-bit and saturate at 255. They can never wrap, because each is cleared on reaching its target.
- Reset asserted mid-hold: the next cycle shows reset values. No emit is produced for a tick coincident with Reset.
- move_valid is never high for two consecutive cycles unless frame_tick was high on two consecutive cycles.

Test Plan:
- Reset with keycode=0x1A held and ticks running -> USER_INPUT=000, move_valid=0, held_dir=000 throughout Reset. The first emit (001) occurs on the 2nd tick after Reset deasserts.
- Defaults, keycode=0x07 held for 20 ticks:
  - move_valid on the cycle after tick 2 with USER_INPUT=101.
  - Next emit after tick 10, then after ticks 12, 14, 16, 18, 20.
  - held_dir=101 from tick 2 onward.
- keycode 0x04 for 1 tick, then 0x00 -> no emit at all, state returns to IDLE, outputs stay 0.
- Direction switch: 0x52 held until the first emit (tick 2), then 0x51 from tick 5 -> no emit at tick 5; 100 emitted after tick 6; held_dir goes 001 -> 000 -> 100.
- Unmapped keycode 0x2C held for 10 ticks -> no emit, held_dir=000. Ticks on consecutive cycles with 0x16 held and STABLE_FRAMES=1 -> emit 100 in the cycle following each qualifying tick.
- Reset pulsed during REPEAT while 0x1A is held -> outputs are 0 the cycle after Reset. Debounce restarts, and the first emit occurs 2 ticks after release.
